// File: rtl/rx_fifo.sv
// Receive-side word buffer for the UART: first-word-fall-through FIFO of 12-bit
// receive words, with empty/full/almost-full flags and a sticky overrun flag.
module rx_fifo #(
    parameter int DEPTH       = 16,
    parameter int AFULL_LEVEL = 12
) (
    input  logic                       baud_clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [11:0]                wr_data,
    input  logic                       receive,
    input  logic                       clr_ovr,
    output logic [11:0]                data_out,
    output logic                       RxFE,
    output logic                       RxFF,
    output logic                       RxAF,
    output logic                       overrun,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [LW-1:0] LVL_ONE   = LW'(1);
    localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);
    localparam logic [LW-1:0] LVL_AFULL = LW'(AFULL_LEVEL);

    logic [11:0]   mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [LW-1:0] level_q;
    logic          overrun_q;
    logic          push_ok;
    logic          pop_ok;
    logic          drop;

    // Handshake: the producer offers a word with wr_en and it is taken when
    // there is room (or a pop frees a slot in the same cycle); the consumer
    // pops the visible head word with receive, which is ignored while empty.
    always_comb begin
        RxFE    = (level_q == '0);
        RxFF    = (level_q == LVL_FULL);
        RxAF    = (level_q >= LVL_AFULL);
        pop_ok  = receive && !RxFE;
        push_ok = wr_en && (!RxFF || pop_ok);
        drop    = wr_en && !push_ok;
    end

    always_ff @(posedge baud_clk) begin
        if (rst) begin
            wp        <= '0;
            rp        <= '0;
            level_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (push_ok) wp <= wp + PTR_ONE;
            if (pop_ok)  rp <= rp + PTR_ONE;
            case ({push_ok, pop_ok})
                2'b10:   level_q <= level_q + LVL_ONE;
                2'b01:   level_q <= level_q - LVL_ONE;
                default: level_q <= level_q;
            endcase
            // A drop outranks the clear so a loss in the clearing cycle is not hidden.
            if (drop)         overrun_q <= 1'b1;
            else if (clr_ovr) overrun_q <= 1'b0;
        end
    end

    // Storage is deliberately left out of reset; the pointers define validity.
    always_ff @(posedge baud_clk) begin
        if (!rst && push_ok) mem[wp] <= wr_data;
    end

    always_comb begin
        data_out = RxFE ? 12'h000 : mem[rp];
        overrun  = overrun_q;
        level    = level_q;
    end

endmodule

// File: tb/tb_rx_fifo.sv
// Self-checking bench for rx_fifo: a vector table, directed corner sequences and
// randomized traffic, all compared against a queue-based reference model.
module tb_rx_fifo;

    localparam int DEPTH = 16;
    localparam int AFL   = 12;

    logic        baud_clk;
    logic        rst;
    logic        wr_en;
    logic [11:0] wr_data;
    logic        receive;
    logic        clr_ovr;
    logic [11:0] data_out;
    logic        RxFE;
    logic        RxFF;
    logic        RxAF;
    logic        overrun;
    logic [4:0]  level;

    rx_fifo #(.DEPTH(DEPTH), .AFULL_LEVEL(AFL)) dut (
        .baud_clk (baud_clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .receive  (receive),
        .clr_ovr  (clr_ovr),
        .data_out (data_out),
        .RxFE     (RxFE),
        .RxFF     (RxFF),
        .RxAF     (RxAF),
        .overrun  (overrun),
        .level    (level)
    );

    // clock/reset block
    initial baud_clk = 1'b0;
    always #5 baud_clk = ~baud_clk;

    // scoreboard state
    logic [11:0] exp_q[$];
    logic        ovr_m;
    int          total;
    int          bad;

    typedef struct {
        logic        r;
        logic        we;
        logic [11:0] wd;
        logic        rc;
        logic        cl;
        logic [4:0]  lvl;
        logic [11:0] dout;
        logic        fe;
        logic        ff;
        logic        af;
        logic        ov;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        int n;
        n = exp_q.size();
        check("model_level", 32'(level), 32'(n));
        check("model_fe", 32'(RxFE), 32'(n == 0));
        check("model_ff", 32'(RxFF), 32'(n == DEPTH));
        check("model_af", 32'(RxAF), 32'(n >= AFL));
        check("model_ovr", 32'(overrun), 32'(ovr_m));
        check("model_dout", 32'(data_out), (n == 0) ? 32'h0 : 32'(exp_q[0]));
    endtask

    // driver: apply one cycle of inputs, advance the model, compare after the edge
    task automatic cycle(input logic r, input logic we, input logic [11:0] wd,
                         input logic rc, input logic cl);
        bit pop_m;
        bit push_m;
        bit full_m;
        rst = r; wr_en = we; wr_data = wd; receive = rc; clr_ovr = cl;
        if (r) begin
            exp_q.delete();
            ovr_m = 1'b0;
        end else begin
            full_m = (exp_q.size() == DEPTH);
            pop_m  = rc && (exp_q.size() != 0);
            push_m = we && (!full_m || pop_m);
            if (pop_m)  void'(exp_q.pop_front());
            if (push_m) exp_q.push_back(wd);
            if (we && !push_m) ovr_m = 1'b1;
            else if (cl)       ovr_m = 1'b0;
        end
        @(posedge baud_clk);
        #1;
        compare_model();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        ovr_m = 1'b0;
        rst = 1'b1; wr_en = 1'b0; wr_data = 12'h000; receive = 1'b0; clr_ovr = 1'b0;

        //                 r     we    wd       rc    cl    lvl    dout     fe    ff    af    ov
        vecs[0]  = '{1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 5'd0, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 5'd0, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 12'h1A5, 1'b0, 1'b0, 5'd1, 12'h1A5, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 12'h2C3, 1'b0, 1'b0, 5'd2, 12'h1A5, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 12'h07F, 1'b0, 1'b0, 5'd3, 12'h1A5, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 5'd2, 12'h2C3, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 5'd1, 12'h07F, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 5'd0, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 5'd0, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 12'h0AA, 1'b1, 1'b0, 5'd1, 12'h0AA, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 5'd1, 12'h0AA, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 5'd0, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 5'd0, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0};

        for (int i = 0; i < 13; i++) begin
            cycle(vecs[i].r, vecs[i].we, vecs[i].wd, vecs[i].rc, vecs[i].cl);
            check("tbl_level", 32'(level), 32'(vecs[i].lvl));
            check("tbl_dout", 32'(data_out), 32'(vecs[i].dout));
            check("tbl_fe", 32'(RxFE), 32'(vecs[i].fe));
            check("tbl_ff", 32'(RxFF), 32'(vecs[i].ff));
            check("tbl_af", 32'(RxAF), 32'(vecs[i].af));
            check("tbl_ovr", 32'(overrun), 32'(vecs[i].ov));
        end

        // fill to full, watching almost-full turn on at the threshold
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b0, 1'b1, 12'(12'h100 + i), 1'b0, 1'b0);
            check("fill_af", 32'(RxAF), 32'(i + 1 >= AFL));
            check("fill_ff", 32'(RxFF), 32'(i + 1 == DEPTH));
        end
        cycle(1'b0, 1'b1, 12'hFFF, 1'b0, 1'b0);
        check("drop_ovr", 32'(overrun), 32'h1);
        check("drop_level", 32'(level), 32'd16);
        check("drop_head", 32'(data_out), 32'h100);
        // a drop in the clearing cycle keeps the flag set
        cycle(1'b0, 1'b1, 12'hFFF, 1'b0, 1'b1);
        check("clr_vs_drop", 32'(overrun), 32'h1);
        cycle(1'b0, 1'b0, 12'h000, 1'b0, 1'b1);
        check("clr_ovr", 32'(overrun), 32'h0);

        // full with simultaneous push and pop across the pointer wrap
        for (int k = 0; k < 20; k++) begin
            cycle(1'b0, 1'b1, 12'(12'h300 + k), 1'b1, 1'b0);
            check("full_pp_level", 32'(level), 32'd16);
            check("full_pp_ovr", 32'(overrun), 32'h0);
        end
        for (int k = 0; k < DEPTH; k++) begin
            check("drain_not_fff", 32'(data_out == 12'hFFF), 32'h0);
            cycle(1'b0, 1'b0, 12'h000, 1'b1, 1'b0);
        end
        check("drained_fe", 32'(RxFE), 32'h1);

        // reset mid-operation discards stored words
        for (int k = 0; k < 5; k++) cycle(1'b0, 1'b1, 12'(12'h050 + k), 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 12'h0EE, 1'b1, 1'b0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_fe", 32'(RxFE), 32'h1);
        check("rst_dout", 32'(data_out), 32'h0);
        cycle(1'b0, 1'b1, 12'h123, 1'b0, 1'b0);
        check("post_rst_head", 32'(data_out), 32'h123);

        // randomized traffic, biased to spend time near both empty and full
        for (int n = 0; n < 3000; n++) begin
            logic r, we, rc, cl;
            int bias;
            bias = (n / 250) % 2;
            r  = ($urandom_range(0, 299) == 0);
            we = (bias == 1) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 3);
            rc = (bias == 1) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 7);
            cl = ($urandom_range(0, 19) == 0);
            cycle(r, we, 12'($urandom), rc, cl);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
